// File: rtl/song_lib_pkg.sv
// Song library constants, note codes and per-song note tables.
// Song 3 (Two Tigers) exists only when SONG_LIB_EXTRA_SONG_EN is defined.
package song_lib_pkg;
  localparam int SONG_LEN  = 61;
  localparam int NOTE_W    = 4;
  localparam int NUM_SONGS = 4;
  localparam int SEL_W     = $clog2(NUM_SONGS);
  localparam int VEC_W     = SONG_LEN * NOTE_W;

  typedef logic [NOTE_W-1:0] note_t;
  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [VEC_W-1:0]  song_vec_t;
  typedef note_t             song_tbl_t [SONG_LEN];

  localparam note_t REST = 4'd0;
  localparam note_t DO   = 4'd1;
  localparam note_t RE   = 4'd2;
  localparam note_t MI   = 4'd3;
  localparam note_t FA   = 4'd4;
  localparam note_t SO   = 4'd5;
  localparam note_t LA   = 4'd6;
  localparam note_t SI   = 4'd7;

  // Twinkle
  localparam song_tbl_t SONG0_TBL = '{
    DO,DO,SO,SO,LA,LA,SO,REST,  FA,FA,MI,MI,RE,RE,DO,REST,
    SO,SO,FA,FA,MI,MI,RE,REST,  SO,SO,FA,FA,MI,MI,RE,REST,
    DO,DO,SO,SO,LA,LA,SO,REST,  FA,FA,MI,MI,RE,RE,DO,REST,
    REST,REST,REST,REST,REST,REST,REST,REST,  REST,REST,REST,REST,REST};

  // Ode to Joy
  localparam song_tbl_t SONG1_TBL = '{
    MI,MI,FA,SO,SO,FA,MI,RE,    DO,DO,RE,MI,MI,RE,RE,REST,
    MI,MI,FA,SO,SO,FA,MI,RE,    DO,DO,RE,MI,RE,DO,DO,REST,
    REST,REST,REST,REST,REST,REST,REST,REST,  REST,REST,REST,REST,REST,REST,REST,REST,
    REST,REST,REST,REST,REST,REST,REST,REST,  REST,REST,REST,REST,REST};

  // Mary had a little lamb
  localparam song_tbl_t SONG2_TBL = '{
    MI,RE,DO,RE,MI,MI,MI,REST,  RE,RE,RE,REST,MI,SO,SO,REST,
    MI,RE,DO,RE,MI,MI,MI,MI,    RE,RE,MI,RE,DO,REST,REST,REST,
    REST,REST,REST,REST,REST,REST,REST,REST,  REST,REST,REST,REST,REST,REST,REST,REST,
    REST,REST,REST,REST,REST,REST,REST,REST,  REST,REST,REST,REST,REST};

`ifdef SONG_LIB_EXTRA_SONG_EN
  // Two Tigers
  localparam song_tbl_t SONG3_TBL = '{
    DO,RE,MI,DO,DO,RE,MI,DO,    MI,FA,SO,REST,MI,FA,SO,REST,
    REST,REST,REST,REST,REST,REST,REST,REST,  REST,REST,REST,REST,REST,REST,REST,REST,
    REST,REST,REST,REST,REST,REST,REST,REST,  REST,REST,REST,REST,REST,REST,REST,REST,
    REST,REST,REST,REST,REST,REST,REST,REST,  REST,REST,REST,REST,REST};
`endif

  // Note i lands in bits [NOTE_W*i +: NOTE_W]
  function automatic song_vec_t pack_song(input song_tbl_t tbl);
    song_vec_t v;
    v = '0;
    for (int i = 0; i < SONG_LEN; i++) v[i*NOTE_W +: NOTE_W] = tbl[i];
    return v;
  endfunction
endpackage

// File: rtl/song_lib_if.sv
// Song select / packed-song bus between the library and its consumer.
interface song_lib_if;
  import song_lib_pkg::*;
  sel_t      song_select;
  song_vec_t song_packed;

  modport master (output song_select, input  song_packed);
  modport slave  (input  song_select, output song_packed);
endinterface

// File: rtl/song_lib_rom.sv
// Combinational song ROM: song index -> packed note vector.
// Entry 3 is built only with SONG_LIB_EXTRA_SONG_EN; otherwise index 3 reads silence.
module song_lib_rom
  import song_lib_pkg::*;
(
  input  sel_t      sel_i,
  output song_vec_t song_o
);
  localparam song_vec_t ROM0 = pack_song(SONG0_TBL);
  localparam song_vec_t ROM1 = pack_song(SONG1_TBL);
  localparam song_vec_t ROM2 = pack_song(SONG2_TBL);
`ifdef SONG_LIB_EXTRA_SONG_EN
  localparam song_vec_t ROM3 = pack_song(SONG3_TBL);
`endif

  always_comb begin
    song_o = '0;
    case (sel_i)
      2'd0:    song_o = ROM0;
      2'd1:    song_o = ROM1;
      2'd2:    song_o = ROM2;
`ifdef SONG_LIB_EXTRA_SONG_EN
      2'd3:    song_o = ROM3;
`endif
      default: song_o = '0;
    endcase
  end
endmodule

// File: rtl/song_lib.sv
// Song library: registered ROM lookup, one clock of latency, async active-high clear.
// Optional fourth song enabled by SONG_LIB_EXTRA_SONG_EN.
module song_lib
  import song_lib_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  song_lib_if.slave  bus
);
  song_vec_t song_d, song_q;

  song_lib_rom u_rom (
    .sel_i  (bus.song_select),
    .song_o (song_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) song_q <= '0;
    else     song_q <= song_d;
  end

  assign bus.song_packed = song_q;
endmodule

// File: tb/tb_song_lib.sv
// Self-checking bench for song_lib against a digit-string song model.
// Honours SONG_LIB_EXTRA_SONG_EN the same way the design does.
module tb_song_lib;
  import song_lib_pkg::*;

  logic clk, rst;
  int   n_tests, n_fail;

  song_lib_if bus ();

  song_lib dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string song_str(input int s);
    case (s)
      0: return "115566504433221055443320554433201155665044332210";
      1: return "33455432112332203345543211232110";
      2: return "321233302220355032123333223210";
`ifdef SONG_LIB_EXTRA_SONG_EN
      3: return "1231123134503450";
`endif
      default: return "";
    endcase
  endfunction

  function automatic logic [3:0] exp_note(input int s, input int i);
    string t;
    t = song_str(s);
    if (i < t.len()) return 4'(t.getc(i) - 8'h30);
    return 4'd0;
  endfunction

  function automatic song_vec_t exp_vec(input int s);
    song_vec_t v;
    v = '0;
    for (int i = 0; i < SONG_LEN; i++) v[4*i +: 4] = exp_note(s, i);
    return v;
  endfunction

  function automatic logic [3:0] dut_note(input int i);
    return bus.song_packed[4*i +: 4];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.song_select = 2'd0;
    #1;
    n_tests++;
    if (bus.song_packed !== '0) begin
      n_fail++; $display("FAIL reset_async got=%h exp=0", bus.song_packed);
    end
    tick(); tick();
    n_tests++;
    if (bus.song_packed !== '0) begin
      n_fail++; $display("FAIL reset_held got=%h exp=0", bus.song_packed);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_tests++;
    if (dut_note(0) !== 4'd1 || dut_note(2) !== 4'd5 || dut_note(4) !== 4'd6 || dut_note(47) !== 4'd0) begin
      n_fail++;
      $display("FAIL song0_spot n0=%0d n2=%0d n4=%0d n47=%0d exp 1 5 6 0", dut_note(0), dut_note(2), dut_note(4), dut_note(47));
    end
    n_tests++;
    if (bus.song_packed !== exp_vec(0)) begin
      n_fail++; $display("FAIL song0_full got=%h exp=%h", bus.song_packed, exp_vec(0));
    end
  endtask

  task automatic test_select_latency();
    @(negedge clk);
    bus.song_select = 2'd1;
    #1;
    n_tests++;
    if (bus.song_packed !== exp_vec(0)) begin
      n_fail++; $display("FAIL latency_before_edge got=%h exp=%h", bus.song_packed, exp_vec(0));
    end
    tick();
    n_tests++;
    if (dut_note(0) !== 4'd3 || dut_note(2) !== 4'd4 || dut_note(3) !== 4'd5 || dut_note(31) !== 4'd0 || dut_note(60) !== 4'd0) begin
      n_fail++;
      $display("FAIL song1_spot n0=%0d n2=%0d n3=%0d n31=%0d n60=%0d exp 3 4 5 0 0", dut_note(0), dut_note(2), dut_note(3), dut_note(31), dut_note(60));
    end
    n_tests++;
    if (bus.song_packed !== exp_vec(1)) begin
      n_fail++; $display("FAIL song1_full got=%h exp=%h", bus.song_packed, exp_vec(1));
    end
  endtask

  task automatic test_song2();
    @(negedge clk);
    bus.song_select = 2'd2;
    tick();
    n_tests++;
    if (dut_note(0) !== 4'd3 || dut_note(1) !== 4'd2 || dut_note(2) !== 4'd1 || dut_note(13) !== 4'd5 || dut_note(29) !== 4'd0) begin
      n_fail++;
      $display("FAIL song2_spot n0=%0d n1=%0d n2=%0d n13=%0d n29=%0d exp 3 2 1 5 0", dut_note(0), dut_note(1), dut_note(2), dut_note(13), dut_note(29));
    end
    n_tests++;
    if (bus.song_packed[243:120] !== '0) begin
      n_fail++; $display("FAIL song2_padding got=%h exp=0", bus.song_packed[243:120]);
    end
    n_tests++;
    if (bus.song_packed !== exp_vec(2)) begin
      n_fail++; $display("FAIL song2_full got=%h exp=%h", bus.song_packed, exp_vec(2));
    end
  endtask

  task automatic test_song3();
    @(negedge clk);
    bus.song_select = 2'd3;
    tick();
`ifdef SONG_LIB_EXTRA_SONG_EN
    n_tests++;
    if (dut_note(8) !== 4'd3 || dut_note(10) !== 4'd5 || dut_note(15) !== 4'd0) begin
      n_fail++;
      $display("FAIL song3_spot n8=%0d n10=%0d n15=%0d exp 3 5 0", dut_note(8), dut_note(10), dut_note(15));
    end
`endif
    n_tests++;
    if (bus.song_packed !== exp_vec(3)) begin
      n_fail++; $display("FAIL song3_full got=%h exp=%h", bus.song_packed, exp_vec(3));
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    bus.song_select = 2'd1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.song_packed !== '0) begin
      n_fail++; $display("FAIL mid_reset_async got=%h exp=0", bus.song_packed);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.song_packed !== '0) begin
      n_fail++; $display("FAIL mid_reset_release_before_edge got=%h exp=0", bus.song_packed);
    end
    tick();
    n_tests++;
    if (bus.song_packed !== exp_vec(1)) begin
      n_fail++; $display("FAIL mid_reset_reload got=%h exp=%h", bus.song_packed, exp_vec(1));
    end
  endtask

  task automatic test_sweep();
    int sel;
    int bad_nib;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      sel = int'($urandom_range(0, 3));
      bus.song_select = 2'(sel);
      tick();
      n_tests++;
      if (bus.song_packed !== exp_vec(sel)) begin
        n_fail++; $display("FAIL sweep_c%0d_sel%0d got=%h exp=%h", c, sel, bus.song_packed, exp_vec(sel));
      end
      bad_nib = 0;
      for (int i = 0; i < SONG_LEN; i++) if (dut_note(i) > 4'd7) bad_nib++;
      n_tests++;
      if (bad_nib !== 0) begin
        n_fail++; $display("FAIL sweep_nibble_range_c%0d bad_nibbles=%0d exp=0", c, bad_nib);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_select_latency();
    test_song2();
    test_song3();
    test_mid_reset();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
